// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the shared single-ported system RAM.
// Round-robin with a bounded burst; one word transaction per grant.
module ram_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req0_ren,
  input  logic        req0_wen,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_store,
  output logic        req0_wait,
  output logic [31:0] req0_load,
  output logic        req0_err,
  input  logic        req1_ren,
  input  logic        req1_wen,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_store,
  output logic        req1_wait,
  output logic [31:0] req1_load,
  output logic        req1_err,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  grant
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        last_owner_q, last_owner_d;

  logic        req0_active, req1_active;
  logic        own0, own1, own, sel;
  logic        sel_ren, sel_wen, sel_active;
  logic [31:0] sel_addr, sel_store;
  logic        done, ram_err, keep_last;

  assign req0_active = req0_ren | req0_wen;
  assign req1_active = req1_ren | req1_wen;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign own  = own0 | own1;
  assign sel  = own1;

  assign sel_ren    = sel ? req1_ren   : req0_ren;
  assign sel_wen    = sel ? req1_wen   : req0_wen;
  assign sel_addr   = sel ? req1_addr  : req0_addr;
  assign sel_store  = sel ? req1_store : req0_store;
  assign sel_active = sel_ren | sel_wen;

  assign ram_err = (ramstate == RAM_ERROR);
  assign done    = own & sel_active & ((ramstate == RAM_ACCESS) | ram_err);

  // A zero count means no burst is running, so a tie goes to the other side.
  assign keep_last = (burst_cnt_q != 4'd0) && (burst_cnt_q < BURST_LIM);

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (req0_active && req1_active) begin
          if (keep_last) begin
            state_d = last_owner_q ? OWN1 : OWN0;
          end else begin
            state_d     = last_owner_q ? OWN0 : OWN1;
            burst_cnt_d = '0;
          end
        end else if (req0_active) begin
          state_d = OWN0;
          if (last_owner_q) burst_cnt_d = '0;
        end else if (req1_active) begin
          state_d = OWN1;
          if (!last_owner_q) burst_cnt_d = '0;
        end else begin
          burst_cnt_d = '0;
        end
      end
      OWN0, OWN1: begin
        if (!sel_active) begin
          state_d = IDLE;
        end else if (done) begin
          state_d      = IDLE;
          burst_cnt_d  = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
          last_owner_d = sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Write wins when a requester raises both strobes.
  assign ramWEN   = own & sel_wen;
  assign ramREN   = own & sel_ren & ~sel_wen;
  assign ramaddr  = own ? sel_addr  : '0;
  assign ramstore = own ? sel_store : '0;
  assign grant    = {own1, own0};

  assign req0_wait = req0_active & ~(own0 & done);
  assign req1_wait = req1_active & ~(own1 & done);
  assign req0_err  = own0 & req0_active & ram_err;
  assign req1_err  = own1 & req1_active & ram_err;
  assign req0_load = ramload;
  assign req1_load = ramload;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter, checked against a
// turn-taking reference model kept in plain integers.
module tb_ram_arbiter;

  localparam int BURST_MAX = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        c_ren[2];
  logic        c_wen[2];
  logic [31:0] c_addr[2];
  logic [31:0] c_store[2];
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic        d_wait[2];
  logic        d_err[2];
  logic [31:0] d_load[2];
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [1:0]  grant;

  ram_arbiter #(.BURST_MAX(BURST_MAX)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req0_ren   (c_ren[0]),
    .req0_wen   (c_wen[0]),
    .req0_addr  (c_addr[0]),
    .req0_store (c_store[0]),
    .req0_wait  (d_wait[0]),
    .req0_load  (d_load[0]),
    .req0_err   (d_err[0]),
    .req1_ren   (c_ren[1]),
    .req1_wen   (c_wen[1]),
    .req1_addr  (c_addr[1]),
    .req1_store (c_store[1]),
    .req1_wait  (d_wait[1]),
    .req1_load  (d_load[1]),
    .req1_err   (d_err[1]),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ramstate   (ramstate),
    .grant      (grant)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds the RAM (-1 none), who finished last, run length.
  int   m_owner;
  int   m_last;
  int   m_cnt;
  logic e_wait[2];
  logic e_err[2];

  int burst_order[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
  endtask

  task automatic model_check();
    logic        act[2];
    logic        busy_done;
    logic [1:0]  g;
    logic        r, w;
    logic [31:0] a, s;
    int          o;
    if (!nRST) model_reset();
    act[0] = c_ren[0] | c_wen[0];
    act[1] = c_ren[1] | c_wen[1];
    busy_done = (ramstate == 2'd2) || (ramstate == 2'd3);
    g = 2'b00; r = 1'b0; w = 1'b0; a = '0; s = '0;
    e_wait[0] = act[0]; e_wait[1] = act[1];
    e_err[0]  = 1'b0;   e_err[1]  = 1'b0;
    if (m_owner >= 0) begin
      o = m_owner;
      g = (o == 1) ? 2'b10 : 2'b01;
      a = c_addr[o];
      s = c_store[o];
      if (act[o]) begin
        w = c_wen[o];
        r = c_ren[o] & ~c_wen[o];
        e_wait[o] = ~busy_done;
        e_err[o]  = (ramstate == 2'd3);
      end
    end
    chk("grant", {30'b0, grant}, {30'b0, g});
    chk("ramREN", {31'b0, ramREN}, {31'b0, r});
    chk("ramWEN", {31'b0, ramWEN}, {31'b0, w});
    chk("ramaddr", ramaddr, a);
    chk("ramstore", ramstore, s);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("wait%0d", i), {31'b0, d_wait[i]}, {31'b0, e_wait[i]});
      chk($sformatf("err%0d", i), {31'b0, d_err[i]}, {31'b0, e_err[i]});
    end
  endtask

  task automatic model_update();
    logic act[2];
    logic busy_done;
    int   win;
    if (!nRST) begin
      model_reset();
      return;
    end
    act[0] = c_ren[0] | c_wen[0];
    act[1] = c_ren[1] | c_wen[1];
    busy_done = (ramstate == 2'd2) || (ramstate == 2'd3);
    if (m_owner < 0) begin
      win = -1;
      if (act[0] && act[1])
        win = (m_cnt >= 1 && m_cnt < BURST_MAX) ? m_last : 1 - m_last;
      else if (act[0])
        win = 0;
      else if (act[1])
        win = 1;
      if (win < 0 || win != m_last) m_cnt = 0;
      m_owner = win;
    end else if (!act[m_owner]) begin
      m_owner = -1;
    end else if (busy_done) begin
      m_cnt   = (m_cnt < 15) ? m_cnt + 1 : 15;
      m_last  = m_owner;
      m_owner = -1;
    end
  endtask

  task automatic half();
    @(negedge CLK);
    model_check();
  endtask

  task automatic edge_();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic tick();
    half();
    edge_();
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++) begin
      c_ren[i] = 1'b0; c_wen[i] = 1'b0;
      c_addr[i] = '0;  c_store[i] = '0;
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    edge_();
    edge_();
    nRST = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_reqs();
    ramload  = '0;
    ramstate = 2'd0;

    // Reset state, including wait following a live request
    c_ren[0] = 1'b1;
    half();
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_wait0", {31'b0, d_wait[0]}, 32'd1);
    edge_();
    c_ren[0] = 1'b0;
    edge_();
    nRST = 1'b1;

    // Read with two BUSY cycles
    c_ren[0] = 1'b1; c_addr[0] = 32'h40;
    half();
    chk("t1_idle", {30'b0, grant}, 32'd0);
    edge_();
    ramstate = 2'd1;
    half();
    chk("t1_grant", {30'b0, grant}, 32'b01);
    chk("t1_addr", ramaddr, 32'h40);
    chk("t1_busy_wait", {31'b0, d_wait[0]}, 32'd1);
    edge_();
    tick();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    half();
    chk("t1_done_wait", {31'b0, d_wait[0]}, 32'd0);
    chk("t1_load", d_load[0], 32'hDEADBEEF);
    edge_();
    c_ren[0] = 1'b0; ramstate = 2'd0;
    half();
    chk("t1_back_idle", {30'b0, grant}, 32'd0);
    edge_();

    // Tie after reset goes to req0, then req1 writes
    do_reset();
    c_ren[0] = 1'b1; c_addr[0] = 32'h100;
    c_wen[1] = 1'b1; c_addr[1] = 32'h200; c_store[1] = 32'h12345678;
    tick();
    ramstate = 2'd1;
    half();
    chk("t2_first", {30'b0, grant}, 32'b01);
    chk("t2_wait1", {31'b0, d_wait[1]}, 32'd1);
    edge_();
    ramstate = 2'd2;
    half();
    chk("t2_wait1_done0", {31'b0, d_wait[1]}, 32'd1);
    edge_();
    c_ren[0] = 1'b0; ramstate = 2'd0;
    tick();
    ramstate = 2'd2;
    half();
    chk("t2_second", {30'b0, grant}, 32'b10);
    chk("t2_wen", {31'b0, ramWEN}, 32'd1);
    chk("t2_store", ramstore, 32'h12345678);
    edge_();
    clear_reqs(); ramstate = 2'd0;
    tick();

    // Bounded burst with both requesters held active
    do_reset();
    c_ren[0] = 1'b1; c_addr[0] = 32'h10;
    c_wen[1] = 1'b1; c_addr[1] = 32'h20; c_store[1] = 32'h1;
    ramstate = 2'd2;
    for (int k = 0; k < 18; k++) begin
      half();
      if (k % 2 == 0)
        chk($sformatf("t3_gap%0d", k / 2), {30'b0, grant}, 32'd0);
      else
        chk($sformatf("t3_grant%0d", k / 2), {30'b0, grant},
            (burst_order[k / 2] == 1) ? 32'b10 : 32'b01);
      edge_();
    end
    clear_reqs(); ramstate = 2'd0;
    tick();

    // RAM error on a req1 write
    c_wen[1] = 1'b1; c_addr[1] = 32'h300; c_store[1] = 32'hA5A5A5A5;
    tick();
    ramstate = 2'd3;
    half();
    chk("t4_err1", {31'b0, d_err[1]}, 32'd1);
    chk("t4_wait1", {31'b0, d_wait[1]}, 32'd0);
    chk("t4_err0", {31'b0, d_err[0]}, 32'd0);
    edge_();
    clear_reqs(); ramstate = 2'd0;
    half();
    chk("t4_err1_gone", {31'b0, d_err[1]}, 32'd0);
    edge_();

    // Both strobes then abort mid-BUSY
    c_ren[0] = 1'b1; c_wen[0] = 1'b1; c_addr[0] = 32'h44; c_store[0] = 32'h99;
    tick();
    ramstate = 2'd1;
    half();
    chk("t5_wen", {31'b0, ramWEN}, 32'd1);
    chk("t5_ren", {31'b0, ramREN}, 32'd0);
    edge_();
    c_ren[0] = 1'b0; c_wen[0] = 1'b0; ramstate = 2'd3;
    half();
    chk("t5_abort_wen", {31'b0, ramWEN}, 32'd0);
    chk("t5_abort_err", {31'b0, d_err[0]}, 32'd0);
    edge_();
    ramstate = 2'd0;
    half();
    chk("t5_idle", {30'b0, grant}, 32'd0);
    edge_();

    // Asynchronous reset while req1 is mid-BUSY
    c_ren[1] = 1'b1; c_addr[1] = 32'h500;
    tick();
    ramstate = 2'd1;
    half();
    chk("t6_own1", {30'b0, grant}, 32'b10);
    nRST = 1'b0;
    #1;
    chk("t6_rst_grant", {30'b0, grant}, 32'd0);
    chk("t6_rst_ren", {31'b0, ramREN}, 32'd0);
    chk("t6_rst_addr", ramaddr, 32'd0);
    model_check();
    edge_();
    edge_();
    nRST = 1'b1;
    c_ren[0] = 1'b1; c_addr[0] = 32'h600; ramstate = 2'd2;
    tick();
    half();
    chk("t6_tie_req0", {30'b0, grant}, 32'b01);
    edge_();
    clear_reqs(); ramstate = 2'd0;
    tick();

    // Randomized cores and RAM against the reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      int unsigned p;
      p = $urandom_range(0, 9);
      ramstate = (p < 2) ? 2'd0 : (p < 5) ? 2'd1 : (p < 9) ? 2'd2 : 2'd3;
      ramload  = $urandom;
      half();
      edge_();
      for (int i = 0; i < 2; i++) begin
        if (c_ren[i] | c_wen[i]) begin
          if (!e_wait[i] || $urandom_range(0, 29) == 0) begin
            c_ren[i] = 1'b0; c_wen[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          p = $urandom_range(0, 2);
          c_ren[i]   = (p != 1);
          c_wen[i]   = (p != 0);
          c_addr[i]  = $urandom;
          c_store[i] = $urandom;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
